// File: rtl/sobel_pkg.sv
// Shared constants and FSM encoding for the Sobel window generator.
package sobel_pkg;

   localparam int unsigned DATA_W_DEF = 8;

   // Border handling modes
   localparam int unsigned PAD_NONE = 0;
   localparam int unsigned PAD_ZERO = 1;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StPadCol = 2'd2,
      StFlush  = 2'd3
   } state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// Line delay: DEPTH-deep, DATA_W-wide shift register that advances only when enabled.
// Contents are never reset; the window generator masks and gates stale data.
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 640
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o
);

   logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

   // Shift one entry in when enabled, otherwise hold
   always_comb begin
      mem_d = mem_q;
      if (en_i) begin
         mem_d = {mem_q[DEPTH-2:0], data_i};
      end
   end

   // Delay line storage
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign data_o = mem_q[DEPTH-1];

endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster-scan 3x3 window generator with optional zero-padded border.
// Processes a virtual raster; in zero-pad mode an extra zero column per row and an extra
// zero row per frame are generated internally so every real pixel gets a centred window.
module sobel_window_gen
   import sobel_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ROWS     = 480,
   parameter int unsigned COLS     = 640,
   parameter int unsigned PAD_MODE = PAD_NONE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    done_i,
   input  logic [DATA_W-1:0]       grayscale_i,
   output logic                    ready_o,
   output logic [DATA_W-1:0]       d0_o,
   output logic [DATA_W-1:0]       d1_o,
   output logic [DATA_W-1:0]       d2_o,
   output logic [DATA_W-1:0]       d3_o,
   output logic [DATA_W-1:0]       d4_o,
   output logic [DATA_W-1:0]       d5_o,
   output logic [DATA_W-1:0]       d6_o,
   output logic [DATA_W-1:0]       d7_o,
   output logic [DATA_W-1:0]       d8_o,
   output logic                    done_o,
   output logic [$clog2(ROWS)-1:0] row_o,
   output logic [$clog2(COLS)-1:0] col_o,
   output logic                    frame_done_o
);

   // Virtual counters reach ROWS / COLS in zero-pad mode
   localparam int unsigned RW   = $clog2(ROWS + 1);
   localparam int unsigned CW   = $clog2(COLS + 1);
   localparam int unsigned RO_W = $clog2(ROWS);
   localparam int unsigned CO_W = $clog2(COLS);

   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [RW-1:0] ROW_PAD  = RW'(ROWS);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [CW-1:0] COL_PAD  = CW'(COLS);
   localparam logic          PAD_ON   = (PAD_MODE == PAD_ZERO);

   state_e                        state_q, state_d;
   logic [RW-1:0]                 vr_q, vr_d;
   logic [CW-1:0]                 vc_q, vc_d;
   logic                          ready_q, ready_d;
   logic                          done_q, done_d;
   logic                          frame_q, frame_d;
   logic [RO_W-1:0]               row_q, row_d;
   logic [CO_W-1:0]               col_q, col_d;
   logic [8:0][DATA_W-1:0]        d_q, d_d;
   // Two older window columns per row: [row][0] = column c-1, [row][1] = column c
   logic [2:0][1:0][DATA_W-1:0]   win_q, win_d;

   logic                          accept;
   logic                          proc;
   logic                          pad_col;
   logic                          lb_en;
   logic                          win_ok;
   logic                          last_win;
   logic [DATA_W-1:0]             pix;
   logic [DATA_W-1:0]             lb0_out;
   logic [DATA_W-1:0]             lb1_out;
   logic [2:0][DATA_W-1:0]        col_in;
   logic [8:0][DATA_W-1:0]        taps;

   sobel_line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (COLS)
   ) u_lb0 (
      .clk    (clk),
      .en_i   (lb_en),
      .data_i (pix),
      .data_o (lb0_out)
   );

   sobel_line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (COLS)
   ) u_lb1 (
      .clk    (clk),
      .en_i   (lb_en),
      .data_i (lb0_out),
      .data_o (lb1_out)
   );

   // Datapath: incoming column, border masking and next window outputs
   always_comb begin
      accept  = done_i && ready_q;
      proc    = accept || (state_q == StPadCol) || (state_q == StFlush);
      pad_col = (vc_q == COL_PAD);
      // Pad-column pixels never enter the line buffers, so they stay COLS deep
      lb_en   = proc && !pad_col;
      pix     = accept ? grayscale_i : '0;

      col_in[0] = pad_col ? '0 : lb1_out;
      col_in[1] = pad_col ? '0 : lb0_out;
      col_in[2] = pix;

      taps = '0;
      for (int i = 0; i < 3; i++) begin
         taps[3*i]   = win_q[i][0];
         taps[3*i+1] = win_q[i][1];
         taps[3*i+2] = col_in[i];
      end
      if (PAD_ON) begin
         for (int i = 0; i < 3; i++) begin
            if (vr_q == RW'(1)) taps[i]     = '0;
            if (vr_q == ROW_PAD) taps[6+i]  = '0;
            if (vc_q == CW'(1)) taps[3*i]   = '0;
            if (pad_col)        taps[3*i+2] = '0;
         end
      end

      if (PAD_ON) begin
         win_ok   = (vr_q != '0) && (vc_q != '0);
         last_win = (vr_q == ROW_PAD) && (vc_q == COL_PAD);
      end else begin
         win_ok   = (vr_q >= RW'(2)) && (vc_q >= CW'(2));
         last_win = (vr_q == ROW_LAST) && (vc_q == COL_LAST);
      end

      win_d = win_q;
      if (proc) begin
         for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = col_in[i];
         end
      end

      done_d  = proc && win_ok;
      frame_d = done_d && last_win;
      d_d     = d_q;
      row_d   = row_q;
      col_d   = col_q;
      if (done_d) begin
         d_d   = taps;
         row_d = RO_W'(vr_q - RW'(1));
         col_d = CO_W'(vc_q - CW'(1));
      end
   end

   // Control FSM: raster position and pad/flush sequencing
   always_comb begin
      state_d = state_q;
      vr_d    = vr_q;
      vc_d    = vc_q;
      unique case (state_q)
         StIdle, StRun: begin
            if (accept) begin
               state_d = StRun;
               if (vc_q != COL_LAST) begin
                  vc_d = vc_q + CW'(1);
               end else if (PAD_ON) begin
                  vc_d    = COL_PAD;
                  state_d = StPadCol;
               end else begin
                  vc_d = '0;
                  if (vr_q == ROW_LAST) begin
                     vr_d    = '0;
                     state_d = StIdle;
                  end else begin
                     vr_d = vr_q + RW'(1);
                  end
               end
            end
         end
         StPadCol: begin
            vc_d = '0;
            if (vr_q == ROW_LAST) begin
               vr_d    = ROW_PAD;
               state_d = StFlush;
            end else begin
               vr_d    = vr_q + RW'(1);
               state_d = StRun;
            end
         end
         StFlush: begin
            if (vc_q == COL_PAD) begin
               vc_d    = '0;
               vr_d    = '0;
               state_d = StIdle;
            end else begin
               vc_d = vc_q + CW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            vr_d    = '0;
            vc_d    = '0;
         end
      endcase
      ready_d = !((state_d == StPadCol) || (state_d == StFlush));
   end

   // State, window array and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         vr_q    <= '0;
         vc_q    <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         frame_q <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
         d_q     <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         vr_q    <= vr_d;
         vc_q    <= vc_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         frame_q <= frame_d;
         row_q   <= row_d;
         col_q   <= col_d;
         d_q     <= d_d;
         win_q   <= win_d;
      end
   end

   assign ready_o      = ready_q;
   assign done_o       = done_q;
   assign frame_done_o = frame_q;
   assign row_o        = row_q;
   assign col_o        = col_q;
   assign d0_o         = d_q[0];
   assign d1_o         = d_q[1];
   assign d2_o         = d_q[2];
   assign d3_o         = d_q[3];
   assign d4_o         = d_q[4];
   assign d5_o         = d_q[5];
   assign d6_o         = d_q[6];
   assign d7_o         = d_q[7];
   assign d8_o         = d_q[8];

endmodule
